// File: rtl/speed_pkg.sv
// ---------------------------------------------------------------------------
// speed_pkg
// Shared definitions for the speed-mode FSM and its consumers.
//   mode_t          : 2-bit speed mode encoding (2'b11 is unused/illegal)
//   DEF_*_DIV       : default tick dividers, in clk cycles per tick
//   DEF_CNT_W       : default counter width, holds max(DEF_*_DIV)-1
//   decode_mode()   : maps a raw 2-bit mode to mode_t, folding 2'b11 to SLOW
// ---------------------------------------------------------------------------
package speed_pkg;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    FAST   = 2'd1,
    TURTLE = 2'd2
  } mode_t;

  localparam int DEF_SLOW_DIV   = 10_000_000;
  localparam int DEF_FAST_DIV   = 5_000_000;
  localparam int DEF_TURTLE_DIV = 20_000_000;
  localparam int DEF_CNT_W      = 25;

  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return FAST;
      2'd2:    return TURTLE;
      default: return SLOW;
    endcase
  endfunction

endpackage

// File: rtl/tick_counter.sv
// ---------------------------------------------------------------------------
// tick_counter
// Generic free-running period counter with registered terminal strobe.
// Counts 0 .. period-1 while enabled, then wraps to 0 and raises o_term for
// one cycle. Holding i_enable low freezes the count; i_clear restarts it.
//
// Ports:
//   clk        in   clock
//   nrst       in   asynchronous active-low reset
//   i_period   in   CNT_W+1  cycles per strobe (>= 1)
//   i_enable   in   1 = count, 0 = hold
//   i_clear    in   synchronous restart, wins over enable
//   o_count    out  CNT_W    current count
//   o_term     out  one-cycle strobe on wrap
// ---------------------------------------------------------------------------
module tick_counter #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [CNT_W:0]   i_period,
  input  logic             i_enable,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_term
);

  logic [CNT_W-1:0] r_count;
  logic             r_term;
  logic [CNT_W:0]   w_count_inc;
  logic             w_at_term;

  // Comparing count+1 against the period with >= also catches a count that
  // is already past a shortened period, so it wraps instead of running on.
  assign w_count_inc = {1'b0, r_count} + (CNT_W+1)'(1);
  assign w_at_term   = (w_count_inc >= i_period);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_term  <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_term  <= 1'b0;
    end else if (i_enable) begin
      if (w_at_term) begin
        r_count <= '0;
        r_term  <= 1'b1;
      end else begin
        r_count <= w_count_inc[CNT_W-1:0];
        r_term  <= 1'b0;
      end
    end else begin
      r_term  <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_term  = r_term;

endmodule

// File: rtl/speed_tick_gen.sv
// ---------------------------------------------------------------------------
// speed_tick_gen
// Turns the speed-mode FSM output into a one-cycle step strobe whose period
// follows the current mode. A change of mode restarts the period from zero
// and is reported with a one-cycle mode_chg pulse; the game logic advances
// exactly one step per tick.
//
// Build option SPEED_TICK_BOOST_EN: adds a boost input that halves the
// active period (floored at 1); a boost edge restarts the period like a
// mode change.
//
// Ports:
//   clk       in   clock
//   nrst      in   asynchronous active-low reset
//   mode      in   2      speed mode (speed_pkg::mode_t encoding)
//   enable    in   1 = run, 0 = pause (count holds)
//   boost     in   halve period (only with SPEED_TICK_BOOST_EN)
//   tick      out  one-cycle step strobe
//   mode_chg  out  one-cycle pulse after a mode (or boost) change
//   count     out  CNT_W  current position within the period
// ---------------------------------------------------------------------------
module speed_tick_gen
  import speed_pkg::*;
#(
  parameter int SLOW_DIV   = DEF_SLOW_DIV,
  parameter int FAST_DIV   = DEF_FAST_DIV,
  parameter int TURTLE_DIV = DEF_TURTLE_DIV,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [1:0]       mode,
  input  logic             enable,
`ifdef SPEED_TICK_BOOST_EN
  input  logic             boost,
`endif
  output logic             tick,
  output logic             mode_chg,
  output logic [CNT_W-1:0] count
);

  // Raw copy (not decoded) so that entering or leaving 2'b11 still counts
  // as a change even though it decodes to the same period as SLOW.
  logic [1:0]     r_mode_q;
  logic           r_mode_chg;
  logic           w_change;
  logic [CNT_W:0] w_period_base;
  logic [CNT_W:0] w_period;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode_q <= SLOW;
    end else begin
      r_mode_q <= mode;
    end
  end

  always_comb begin
    w_period_base = (CNT_W+1)'(SLOW_DIV);
    case (decode_mode(r_mode_q))
      FAST:    w_period_base = (CNT_W+1)'(FAST_DIV);
      TURTLE:  w_period_base = (CNT_W+1)'(TURTLE_DIV);
      default: w_period_base = (CNT_W+1)'(SLOW_DIV);
    endcase
  end

`ifdef SPEED_TICK_BOOST_EN
  logic           r_boost_q;
  logic [CNT_W:0] w_period_half;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_boost_q <= 1'b0;
    end else begin
      r_boost_q <= boost;
    end
  end

  always_comb begin
    w_period_half = w_period_base >> 1;
    if (w_period_half == '0) begin
      w_period_half = (CNT_W+1)'(1);
    end
    w_period = r_boost_q ? w_period_half : w_period_base;
  end

  assign w_change = (mode != r_mode_q) || (boost != r_boost_q);
`else
  assign w_period = w_period_base;
  assign w_change = (mode != r_mode_q);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode_chg <= 1'b0;
    end else begin
      r_mode_chg <= w_change;
    end
  end

  // The change is seen combinationally against the registered copy and
  // used as the counter's clear, so the new period starts from 0 on the
  // same edge that raises mode_chg, and any pending stale tick is dropped.
  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk      (clk),
    .nrst     (nrst),
    .i_period (w_period),
    .i_enable (enable),
    .i_clear  (w_change),
    .o_count  (count),
    .o_term   (tick)
  );

  assign mode_chg = r_mode_chg;

endmodule

// File: tb/tb_speed_tick_gen.sv
module tb_speed_tick_gen;

  localparam int SLOW_DIV   = 8;
  localparam int FAST_DIV   = 4;
  localparam int TURTLE_DIV = 16;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             nrst;
  logic [1:0]       mode;
  logic             enable;
  logic             boost;
  logic             tick;
  logic             mode_chg;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  speed_tick_gen #(
    .SLOW_DIV   (SLOW_DIV),
    .FAST_DIV   (FAST_DIV),
    .TURTLE_DIV (TURTLE_DIV),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .mode     (mode),
    .enable   (enable),
`ifdef SPEED_TICK_BOOST_EN
    .boost    (boost),
`endif
    .tick     (tick),
    .mode_chg (mode_chg),
    .count    (count)
  );

  // Reference model: elapsed cycles in the current period, restarted on any
  // change of the requested mode/boost; a tick is due once the elapsed
  // count reaches the period of the mode in force.
  int         m_cnt;
  logic       m_tick;
  logic       m_chg;
  logic [1:0] m_mode;
  logic       m_boost;

  function automatic int period_of(input logic [1:0] m, input logic b);
    int p;
    case (m)
      2'd1:    p = FAST_DIV;
      2'd2:    p = TURTLE_DIV;
      default: p = SLOW_DIV;
    endcase
    if (b) p = (p / 2 < 1) ? 1 : p / 2;
    return p;
  endfunction

  always @(posedge clk or negedge nrst) begin : model
    int   c;
    logic t;
    logic g;
    if (!nrst) begin
      m_cnt   <= 0;
      m_tick  <= 1'b0;
      m_chg   <= 1'b0;
      m_mode  <= 2'd0;
      m_boost <= 1'b0;
    end else begin
      c = m_cnt;
      t = 1'b0;
      g = 1'b0;
      if (mode != m_mode || boost != m_boost) begin
        g = 1'b1;
        c = 0;
      end else if (enable) begin
        c = c + 1;
        if (c >= period_of(m_mode, m_boost)) begin
          c = 0;
          t = 1'b1;
        end
      end
      m_cnt   <= c;
      m_tick  <= t;
      m_chg   <= g;
      m_mode  <= mode;
      m_boost <= boost;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; mode = 2'd0; enable = 1'b1; boost = 1'b0;
    repeat (3) adv();
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_cmp++; if (mode_chg !== 1'b0) begin n_bad++; $display("FAIL reset_mode_chg got=%b exp=0", mode_chg); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_slow_run();
    for (int k = 1; k <= 26; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 8)) begin n_bad++; $display("FAIL slow_count cyc=%0d got=%0d exp=%0d", k, count, k % 8); end
      n_cmp++; if (tick !== (k % 8 == 0)) begin n_bad++; $display("FAIL slow_tick cyc=%0d got=%b exp=%b", k, tick, (k % 8 == 0)); end
      n_cmp++; if (mode_chg !== 1'b0) begin n_bad++; $display("FAIL slow_mode_chg cyc=%0d got=%b exp=0", k, mode_chg); end
      n_cmp++; if (tick !== m_tick || count !== CNT_W'(m_cnt)) begin n_bad++; $display("FAIL slow_model cyc=%0d tick=%b/%b count=%0d/%0d", k, tick, m_tick, count, m_cnt); end
    end
  endtask

  task automatic test_mode_switch();
    int lim = 0;
    while (count !== CNT_W'(5) && lim < 40) begin adv(); lim++; end
    n_cmp++; if (count !== CNT_W'(5)) begin n_bad++; $display("FAIL switch_wait timeout count=%0d exp=5", count); end
    mode = 2'd1;
    adv();
    n_cmp++; if (mode_chg !== 1'b1) begin n_bad++; $display("FAIL switch_chg got=%b exp=1", mode_chg); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL switch_tick got=%b exp=0", tick); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL switch_count got=%0d exp=0", count); end
    for (int k = 1; k <= 12; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 4)) begin n_bad++; $display("FAIL fast_count cyc=%0d got=%0d exp=%0d", k, count, k % 4); end
      n_cmp++; if (tick !== (k % 4 == 0)) begin n_bad++; $display("FAIL fast_tick cyc=%0d got=%b exp=%b", k, tick, (k % 4 == 0)); end
      n_cmp++; if (mode_chg !== 1'b0) begin n_bad++; $display("FAIL fast_mode_chg cyc=%0d got=%b exp=0", k, mode_chg); end
    end
  endtask

  task automatic test_pause();
    int lim = 0;
    mode = 2'd0;
    adv();
    n_cmp++; if (mode_chg !== 1'b1 || count !== '0) begin n_bad++; $display("FAIL pause_entry chg=%b count=%0d exp chg=1 count=0", mode_chg, count); end
    while (count !== CNT_W'(3) && lim < 40) begin adv(); lim++; end
    n_cmp++; if (count !== CNT_W'(3)) begin n_bad++; $display("FAIL pause_wait timeout count=%0d exp=3", count); end
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(3) || tick !== 1'b0) begin n_bad++; $display("FAIL pause_hold cyc=%0d count=%0d tick=%b exp count=3 tick=0", k, count, tick); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'((3 + k) % 8)) begin n_bad++; $display("FAIL resume_count cyc=%0d got=%0d exp=%0d", k, count, (3 + k) % 8); end
      n_cmp++; if (tick !== (k == 5)) begin n_bad++; $display("FAIL resume_tick cyc=%0d got=%b exp=%b", k, tick, (k == 5)); end
    end
    adv();
    enable = 1'b0;
    mode = 2'd1;
    adv();
    n_cmp++; if (mode_chg !== 1'b1 || count !== '0 || tick !== 1'b0) begin n_bad++; $display("FAIL paused_change chg=%b count=%0d tick=%b exp 1/0/0", mode_chg, count, tick); end
    adv();
    n_cmp++; if (mode_chg !== 1'b0 || count !== '0 || tick !== 1'b0) begin n_bad++; $display("FAIL paused_after chg=%b count=%0d tick=%b exp 0/0/0", mode_chg, count, tick); end
    enable = 1'b1;
  endtask

  task automatic test_illegal();
    mode = 2'b11;
    adv();
    n_cmp++; if (mode_chg !== 1'b1 || count !== '0) begin n_bad++; $display("FAIL illegal_entry chg=%b count=%0d exp 1/0", mode_chg, count); end
    for (int k = 1; k <= 20; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 8)) begin n_bad++; $display("FAIL illegal_count cyc=%0d got=%0d exp=%0d", k, count, k % 8); end
      n_cmp++; if (tick !== (k % 8 == 0)) begin n_bad++; $display("FAIL illegal_tick cyc=%0d got=%b exp=%b", k, tick, (k % 8 == 0)); end
      n_cmp++; if (mode_chg !== 1'b0) begin n_bad++; $display("FAIL illegal_mode_chg cyc=%0d got=%b exp=0", k, mode_chg); end
    end
  endtask

  task automatic test_async_reset();
    int lim = 0;
    mode = 2'd2;
    adv();
    n_cmp++; if (mode_chg !== 1'b1) begin n_bad++; $display("FAIL turtle_entry chg=%b exp=1", mode_chg); end
    while (count !== CNT_W'(12) && lim < 40) begin adv(); lim++; end
    n_cmp++; if (count !== CNT_W'(12)) begin n_bad++; $display("FAIL turtle_wait timeout count=%0d exp=12", count); end
    #2;
    nrst = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || tick !== 1'b0 || mode_chg !== 1'b0) begin n_bad++; $display("FAIL async_reset count=%0d tick=%b chg=%b exp 0/0/0", count, tick, mode_chg); end
    mode = 2'd0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 8) || tick !== (k % 8 == 0) || mode_chg !== 1'b0) begin
        n_bad++; $display("FAIL post_reset cyc=%0d count=%0d tick=%b chg=%b exp count=%0d tick=%b chg=0", k, count, tick, mode_chg, k % 8, (k % 8 == 0));
      end
    end
  endtask

`ifdef SPEED_TICK_BOOST_EN
  task automatic test_boost();
    mode = 2'd1;
    boost = 1'b1;
    adv();
    n_cmp++; if (mode_chg !== 1'b1 || count !== '0) begin n_bad++; $display("FAIL boost_entry chg=%b count=%0d exp 1/0", mode_chg, count); end
    for (int k = 1; k <= 8; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 2) || tick !== (k % 2 == 0)) begin n_bad++; $display("FAIL boost_run cyc=%0d count=%0d tick=%b exp %0d/%b", k, count, tick, k % 2, (k % 2 == 0)); end
    end
    adv();
    boost = 1'b0;
    adv();
    n_cmp++; if (mode_chg !== 1'b1 || count !== '0 || tick !== 1'b0) begin n_bad++; $display("FAIL boost_off chg=%b count=%0d tick=%b exp 1/0/0", mode_chg, count, tick); end
    for (int k = 1; k <= 8; k++) begin
      adv();
      n_cmp++; if (count !== CNT_W'(k % 4) || tick !== (k % 4 == 0)) begin n_bad++; $display("FAIL unboost_run cyc=%0d count=%0d tick=%b exp %0d/%b", k, count, tick, k % 4, (k % 4 == 0)); end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      enable = ($urandom_range(9) < 8);
`ifdef SPEED_TICK_BOOST_EN
      if ($urandom_range(15) == 0) boost = ~boost;
`endif
      adv();
      n_cmp++; if (tick !== m_tick) begin n_bad++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", k, tick, m_tick); end
      n_cmp++; if (count !== CNT_W'(m_cnt)) begin n_bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", k, count, m_cnt); end
      n_cmp++; if (mode_chg !== m_chg) begin n_bad++; $display("FAIL rand_mode_chg cyc=%0d got=%b exp=%b", k, mode_chg, m_chg); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_slow_run();
    test_mode_switch();
    test_pause();
    test_illegal();
    test_async_reset();
`ifdef SPEED_TICK_BOOST_EN
    test_boost();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
